// File: rtl/frag_fifo_reader.sv
// frag_fifo_reader: pops FRAG_WORDS FIFO words into one fragment record, computes its pixel address and hands it downstream.
// Define FRAG_BOUNDS_CHECK_EN to discard fragments lying outside resx x resy.
module frag_fifo_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAG_WORDS = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             en,
   input  logic [DATA_WIDTH-1:0]            frag_fifo_rd_data,
   input  logic                             frag_fifo_empty,
   output logic                             frag_fifo_rd_en,
   input  logic [31:0]                      resx,
   input  logic [31:0]                      resy,
   output logic                             frag_valid,
   input  logic                             frag_ready,
   output logic [DATA_WIDTH*FRAG_WORDS-1:0] frag_data,
   output logic [31:0]                      frag_addr,
   output logic                             busy,
   output logic [CNT_WIDTH-1:0]             frag_count,
   output logic [CNT_WIDTH-1:0]             drop_count
);
   localparam int IW = $clog2(FRAG_WORDS + 1);
   localparam logic [1:0] FILL = 2'd0, ADDR = 2'd1, OUT = 2'd2;
   logic [1:0] state;
   logic [IW-1:0] issued, captured;
   logic pend;
   logic [31:0] x, y;
   assign x = 32'(frag_data[0 +: DATA_WIDTH]);
   assign y = 32'(frag_data[DATA_WIDTH +: DATA_WIDTH]);
   assign frag_fifo_rd_en = !reset && state == FILL && en && !frag_fifo_empty && issued < IW'(FRAG_WORDS);
   assign busy = state != FILL || captured != '0 || issued != '0;
`ifdef FRAG_BOUNDS_CHECK_EN
   logic oob;
   assign oob = x >= resx || y >= resy;
`else
   logic unused;
   assign unused = ^resy;
   assign drop_count = '0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FILL;
         issued     <= '0;
         captured   <= '0;
         pend       <= 1'b0;
         frag_valid <= 1'b0;
         frag_data  <= '0;
         frag_addr  <= '0;
         frag_count <= '0;
`ifdef FRAG_BOUNDS_CHECK_EN
         drop_count <= '0;
`endif
      end else begin
         // data returns one cycle after the strobe, so capture trails issue
         pend <= frag_fifo_rd_en;
         case (state)
            FILL: begin
               issued <= issued + IW'(frag_fifo_rd_en);
               if (pend) begin
                  frag_data[captured*DATA_WIDTH +: DATA_WIDTH] <= frag_fifo_rd_data;
                  captured <= captured + IW'(1);
                  if (captured == IW'(FRAG_WORDS - 1)) begin
                     captured <= '0;
                     issued   <= '0;
                     state    <= ADDR;
                  end
               end
            end
            ADDR: begin
               frag_addr <= y * resx + x;
`ifdef FRAG_BOUNDS_CHECK_EN
               frag_valid <= !oob;
               state      <= oob ? FILL : OUT;
               drop_count <= drop_count + CNT_WIDTH'(oob);
`else
               frag_valid <= 1'b1;
               state      <= OUT;
`endif
            end
            OUT: begin
               if (frag_ready) begin
                  frag_valid <= 1'b0;
                  frag_count <= frag_count + CNT_WIDTH'(1);
                  state      <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_frag_fifo_reader.sv
// tb_frag_fifo_reader: drives frag_fifo_reader from a queue-modelled FIFO and checks every record against a scoreboard.
// Expectations follow FRAG_BOUNDS_CHECK_EN when it is defined for the build.
module tb_frag_fifo_reader;
`ifdef FRAG_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, en = 1'b1, frag_ready = 1'b1, frag_fifo_empty = 1'b1;
   logic [31:0] frag_fifo_rd_data = '0, resx = 32'd1920, resy = 32'd1080;
   logic frag_fifo_rd_en, frag_valid, busy;
   logic [255:0] frag_data;
   logic [31:0] frag_addr;
   logic [15:0] frag_count, drop_count;
   frag_fifo_reader dut (
      .clk(clk), .reset(reset), .en(en), .frag_fifo_rd_data(frag_fifo_rd_data),
      .frag_fifo_empty(frag_fifo_empty), .frag_fifo_rd_en(frag_fifo_rd_en),
      .resx(resx), .resy(resy), .frag_valid(frag_valid), .frag_ready(frag_ready),
      .frag_data(frag_data), .frag_addr(frag_addr), .busy(busy),
      .frag_count(frag_count), .drop_count(drop_count)
   );
   always #5 clk = ~clk;
   typedef struct { logic [255:0] data; logic [31:0] addr; } rec_t;
   typedef struct { logic [31:0] x, y, rx, ry, addr; bit oob; } vec_t;
   rec_t exp_q[$];
   logic [31:0] fq[$], src[$];
   int checks = 0, failures = 0, exp_frags = 0, exp_drops = 0, gap = 0, cyc = 0, rd_total = 0;
   bit ready_lvl = 1'b1, rnd_ready = 1'b0, rnd_en = 1'b0, prev_hold = 1'b0;
   logic s_rd, s_valid, s_busy;
   logic [31:0] s_addr, prev_addr;
   logic [255:0] prev_data;
   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic push_frag(input logic [31:0] x, input logic [31:0] y, input logic [191:0] attrs,
                            input logic [31:0] addr, input bit drop);
      rec_t r;
      logic [255:0] d;
      d = {attrs, y, x};
      for (int i = 0; i < 8; i++) begin
         if (gap == 0) fq.push_back(d[i*32 +: 32]);
         else src.push_back(d[i*32 +: 32]);
      end
      if (drop) exp_drops++;
      else begin
         r.data = d;
         r.addr = addr;
         exp_q.push_back(r);
      end
   endtask
   // One clock: set inputs on the falling edge, sample and score, then model the FIFO pop
   task automatic cycle();
      rec_t e;
      @(negedge clk);
      if (gap != 0 && src.size() != 0 && cyc % gap == 0) fq.push_back(src.pop_front());
      frag_fifo_empty = fq.size() == 0;
      frag_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
      if (rnd_en) en = $urandom_range(0, 3) != 0;
      #1;
      s_rd = frag_fifo_rd_en;
      s_valid = frag_valid;
      s_busy = busy;
      s_addr = frag_addr;
      rd_total += int'(s_rd);
      if (!reset) begin
         if (s_rd) begin
            check("rd_while_empty", frag_fifo_empty, 0);
            check("rd_while_valid", frag_valid, 0);
         end
         if (prev_hold) begin
            check("hold_valid", frag_valid, 1);
            check("hold_data", frag_data, prev_data);
            check("hold_addr", frag_addr, prev_addr);
         end
         if (frag_valid && frag_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_record: got addr %0d, expected no record", frag_addr);
            end else begin
               e = exp_q.pop_front();
               check("rec_data", frag_data, e.data);
               check("rec_addr", frag_addr, e.addr);
               exp_frags++;
            end
         end
         prev_hold = frag_valid && !frag_ready;
         prev_data = frag_data;
         prev_addr = frag_addr;
      end else prev_hold = 1'b0;
      @(posedge clk);
      #1;
      if (s_rd && fq.size() != 0) frag_fifo_rd_data = fq.pop_front();
      cyc++;
   endtask
   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fq.size() != 0 || src.size() != 0 || busy) && n < limit) begin
         cycle();
         n++;
      end
      if (n >= limit) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", limit);
      end
      cycle();
   endtask
   initial begin
      vec_t tv[7];
      logic [31:0] x, y, rx, ry;
      logic [63:0] p;
      int base, n;
      tv[0] = '{32'd3, 32'd2, 32'd1920, 32'd1080, 32'd3843, 1'b0};
      tv[1] = '{32'd0, 32'd0, 32'd1920, 32'd1080, 32'd0, 1'b0};
      tv[2] = '{32'd1920, 32'd0, 32'd1920, 32'd1080, 32'd1920, 1'b1};
      tv[3] = '{32'd1919, 32'd1079, 32'd1920, 32'd1080, 32'd2073599, 1'b0};
      tv[4] = '{32'd5, 32'd1080, 32'd1920, 32'd1080, 32'd2073605, 1'b1};
      tv[5] = '{32'd100, 32'h1000_0000, 32'd256, 32'hFFFF_FFFF, 32'd100, 1'b0};
      tv[6] = '{32'd7, 32'd3, 32'd1, 32'd1, 32'd10, 1'b1};
      // reset with a full fragment already waiting in the FIFO
      push_frag(32'd3, 32'd2, {128'd0, 32'h3f800000, 32'h3f800000}, 32'd3843, 1'b0);
      cycle();
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("reset_rd_en", s_rd, 0);
         check("reset_valid", s_valid, 0);
         check("reset_busy", s_busy, 0);
         check("reset_addr", s_addr, 0);
         check("reset_frag_count", frag_count, 0);
         check("reset_drop_count", drop_count, 0);
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("single_rd_burst", s_rd, 1);
      end
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("single_gap_rd", s_rd, 0);
         check("single_gap_valid", s_valid, 0);
      end
      cycle();
      check("single_valid", s_valid, 1);
      check("single_addr", s_addr, 32'd3843);
      cycle();
      check("single_valid_drop", s_valid, 0);
      check("single_frag_count", frag_count, 1);
      // backpressure: second fragment must wait behind the held first one
      ready_lvl = 1'b0;
      push_frag(32'd10, 32'd20, {6{32'h1234_5678}}, 32'd38410, 1'b0);
      push_frag(32'd11, 32'd21, {6{32'h9abc_def0}}, 32'd40331, 1'b0);
      n = 0;
      while (!s_valid && n < 60) begin
         cycle();
         n++;
      end
      check("bp_valid_rises", s_valid, 1);
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("bp_no_rd", s_rd, 0);
         check("bp_held", s_valid, 1);
      end
      ready_lvl = 1'b1;
      drain(200);
      check("bp_frag_count", frag_count, 3);
      // sparse FIFO: one word every third cycle
      gap = 3;
      push_frag(32'd7, 32'd9, {6{32'h0bad_cafe}}, 32'd17287, 1'b0);
      drain(300);
      gap = 0;
      // en dropped after four reads
      push_frag(32'd1, 32'd1, {6{32'h5555_aaaa}}, 32'd1921, 1'b0);
      base = rd_total;
      n = 0;
      while (rd_total < base + 4 && n < 50) begin
         cycle();
         n++;
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("en_low_no_rd", s_rd, 0);
         check("en_low_busy", s_busy, 1);
      end
      en = 1'b1;
      drain(200);
      check("en_frag_count", frag_count, 5);
      for (int i = 0; i < 7; i++) begin
         resx = tv[i].rx;
         resy = tv[i].ry;
         push_frag(tv[i].x, tv[i].y, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                   tv[i].addr, BC && tv[i].oob);
         drain(200);
      end
      check("table_drop_count", drop_count, 16'(exp_drops));
      // random traffic scored against plain address arithmetic
      rnd_ready = 1'b1;
      rnd_en = 1'b1;
      for (int b = 0; b < 8; b++) begin
         rx = $urandom_range(1, 1 << 20);
         ry = $urandom_range(1, 1 << 20);
         resx = rx;
         resy = ry;
         gap = $urandom_range(0, 2);
         for (int f = 0; f < 8; f++) begin
            x = $urandom_range(0, rx + rx / 8);
            y = $urandom_range(0, ry + ry / 8);
            p = 64'(y) * 64'(rx) + 64'(x);
            push_frag(x, y, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                      p[31:0], BC && (x >= rx || y >= ry));
         end
         drain(4000);
      end
      rnd_ready = 1'b0;
      rnd_en = 1'b0;
      en = 1'b1;
      gap = 0;
      check("final_frag_count", frag_count, 16'(exp_frags));
      check("final_drop_count", drop_count, 16'(exp_drops));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
